// File: rtl/demux_tdm_rx_pkg.sv
// demux_tdm_rx shared types and helpers.
// Lane-width helper, one-hot decode and error-counter width.
package demux_pkg;

    localparam int MAX_LANES = 16;
    localparam int ERR_CNT_W = 8;

    function automatic int lane_w(input int lanes);
        return (lanes < 2) ? 1 : $clog2(lanes);
    endfunction

    function automatic logic [MAX_LANES-1:0] onehot(input logic [3:0] idx);
        logic [MAX_LANES-1:0] r;
        r = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/demux_tdm_rx_if.sv
// TDM receive bus: serial word in, parallel lanes out.
// SYNC_ERR_EN adds sync_err and err_count.
interface demux_tdm_rx_if
    import demux_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int LANES  = 4,
    localparam int LANE_W = lane_w(LANES)
);
    logic [WIDTH-1:0]       data_in;
    logic                   valid_in;
    logic                   sync_in;
    logic [LANES*WIDTH-1:0] data_out;
    logic [LANES-1:0]       valid_out;
    logic                   frame_done;
    logic [LANE_W-1:0]      lane_idx;
`ifdef SYNC_ERR_EN
    logic                   sync_err;
    logic [ERR_CNT_W-1:0]   err_count;
`endif

    modport master (
        output data_in, valid_in, sync_in,
        input  data_out, valid_out, frame_done, lane_idx
`ifdef SYNC_ERR_EN
        , input sync_err, err_count
`endif
    );

    modport slave (
        input  data_in, valid_in, sync_in,
        output data_out, valid_out, frame_done, lane_idx
`ifdef SYNC_ERR_EN
        , output sync_err, err_count
`endif
    );

endinterface

// File: rtl/demux_tdm_rx_lane_ptr.sv
// Lane pointer: round-robin counter with wrap and sync-forced return
// to lane 0; the pointer state is the frame position.
module demux_tdm_rx_lane_ptr
    import demux_pkg::*;
#(
    parameter int LANES  = 4,
    localparam int LANE_W = lane_w(LANES)
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              valid_in,
    input  logic              sync_in,
    output logic [LANE_W-1:0] target,
    output logic [LANE_W-1:0] next_idx,
    output logic [LANE_W-1:0] lane_idx,
    output logic              wrap,
    output logic              trunc
);

    always_comb begin
        target   = sync_in ? '0 : lane_idx;
        wrap     = (target == LANE_W'(LANES - 1));
        next_idx = wrap ? '0 : target + 1'b1;
        trunc    = valid_in & sync_in & (lane_idx != '0);
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            lane_idx <= '0;
        end else if (valid_in) begin
            lane_idx <= next_idx;
        end
    end

endmodule

// File: rtl/demux_tdm_rx.sv
// TDM receive demux: scatters words round-robin into lane registers.
// SYNC_ERR_EN enables truncation reporting (sync_err, err_count).
module demux_tdm_rx
    import demux_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int LANES  = 4,
    localparam int LANE_W = lane_w(LANES)
) (
    input  logic           clk,
    input  logic           reset_L,
    demux_tdm_rx_if.slave  bus
);

    logic [LANE_W-1:0]    target;
    logic [LANE_W-1:0]    next_idx;
    logic                 wrap;
    logic                 trunc;
    logic [MAX_LANES-1:0] hot;

    demux_tdm_rx_lane_ptr #(.LANES(LANES)) u_ptr (
        .clk      (clk),
        .reset_L  (reset_L),
        .valid_in (bus.valid_in),
        .sync_in  (bus.sync_in),
        .target   (target),
        .next_idx (next_idx),
        .lane_idx (bus.lane_idx),
        .wrap     (wrap),
        .trunc    (trunc)
    );

    assign hot = onehot(4'(target));

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            bus.data_out   <= '0;
            bus.valid_out  <= '0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.valid_out  <= bus.valid_in ? hot[LANES-1:0] : '0;
            bus.frame_done <= bus.valid_in & wrap;
            for (int k = 0; k < LANES; k++) begin
                if (bus.valid_in && hot[k]) begin
                    bus.data_out[k*WIDTH +: WIDTH] <= bus.data_in;
                end
            end
        end
    end

`ifdef SYNC_ERR_EN
    // Counter saturates so a noisy link cannot roll it back to a small value.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            bus.sync_err  <= 1'b0;
            bus.err_count <= '0;
        end else begin
            bus.sync_err <= trunc;
            if (trunc && bus.err_count != '1) begin
                bus.err_count <= bus.err_count + 1'b1;
            end
        end
    end
`endif

endmodule
